// File: rtl/read_burst_seq_rwds_if.sv
// Source-side handshake between the RWDS-domain read burst sequencer and the
// read CDC FIFO. The sequencer is the master (drives valid/data); the FIFO
// write port is the slave (drives ready).
interface read_burst_seq_rwds_if #(
    parameter int DATA_W = 16
) ();
    logic              fifo_valid;
    logic [DATA_W:0]   fifo_data;   // {last, word}; last is the MSB
    logic              fifo_ready;

    modport master (
        output fifo_valid,
        output fifo_data,
        input  fifo_ready
    );

    modport slave (
        input  fifo_valid,
        input  fifo_data,
        output fifo_ready
    );
endinterface

// File: rtl/read_burst_seq_rwds.sv
// Read burst sequencer in the gated RWDS clock domain.
// Drops the configured number of pipeline-fill words, then forwards exactly
// cfg_burst_len_i deserialised words to the CDC FIFO, tagging the final one
// with LAST. After that it stays quiet until the next reset. The FIFO cannot
// stall RWDS, so a word presented while the FIFO is not ready is lost and
// flagged on a sticky overflow bit. clk_rwds only runs while RWDS toggles,
// so every bit of progress here is counted in clock edges, never in time.
module read_burst_seq_rwds #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int SKIP_W = 2
) (
    input  logic                  clk_rwds,
    input  logic                  resetReadModule,
    input  logic [LEN_W-1:0]      cfg_burst_len_i,
    input  logic [SKIP_W-1:0]     cfg_skip_i,
    input  logic [DATA_W-1:0]     ddr_data_i,
    read_burst_seq_rwds_if.master fifo,
    output logic [LEN_W-1:0]      word_cnt_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Saturation limit for the forwarded-word counter.
    localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

    state_t              state_r;
    state_t              state_nxt_s;

    logic [LEN_W-1:0]    remaining_r;
    logic [LEN_W-1:0]    remaining_nxt_s;
    logic [SKIP_W-1:0]   skip_r;
    logic [SKIP_W-1:0]   skip_nxt_s;
    logic                fifo_valid_r;
    logic                fifo_valid_nxt_s;
    logic [DATA_W:0]     fifo_data_r;
    logic [DATA_W:0]     fifo_data_nxt_s;
    logic [LEN_W-1:0]    word_cnt_r;
    logic [LEN_W-1:0]    word_cnt_nxt_s;
    logic                done_r;
    logic                done_nxt_s;
    logic                overflow_r;
    logic                overflow_nxt_s;

    // A word is lost whenever one is on the bus and the FIFO refuses it.
    logic                word_lost_s;
    assign word_lost_s = fifo_valid_r & ~fifo.fifo_ready;

    // State register; reset returns to IDLE immediately, abandoning any burst.
    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-datapath decode; everything holds unless a state says otherwise.
    always_comb begin
        state_nxt_s      = state_r;
        remaining_nxt_s  = remaining_r;
        skip_nxt_s       = skip_r;
        fifo_valid_nxt_s = fifo_valid_r;
        fifo_data_nxt_s  = fifo_data_r;
        word_cnt_nxt_s   = word_cnt_r;
        done_nxt_s       = done_r;

        // Overflow is sticky and independent of the sequencing below.
        if (word_lost_s) begin
            overflow_nxt_s = 1'b1;
        end else begin
            overflow_nxt_s = overflow_r;
        end

        case (state_r)
            ST_IDLE: begin
                // First edge of the burst: latch config, drop this word.
                remaining_nxt_s  = cfg_burst_len_i;
                skip_nxt_s       = cfg_skip_i;
                fifo_valid_nxt_s = 1'b0;
                if (cfg_burst_len_i == {LEN_W{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                    done_nxt_s  = 1'b1;
                end else if (cfg_skip_i != {SKIP_W{1'b0}}) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end

            ST_FILL: begin
                // Discard pipeline-fill words; the skip count never wraps.
                fifo_valid_nxt_s = 1'b0;
                if (skip_r != {SKIP_W{1'b0}}) begin
                    skip_nxt_s = skip_r - SKIP_W'(1);
                end else begin
                    skip_nxt_s = skip_r;
                end
                // skip_r of 0 cannot occur here, but never strand the FSM in FILL.
                if (skip_r <= SKIP_W'(1)) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end

            ST_STREAM: begin
                if (remaining_r != {LEN_W{1'b0}}) begin
                    // Forward this word, tagging LAST when it is the final one.
                    fifo_valid_nxt_s = 1'b1;
                    fifo_data_nxt_s  = {(remaining_r == LEN_W'(1)), ddr_data_i};
                    remaining_nxt_s  = remaining_r - LEN_W'(1);
                    if (word_cnt_r != CNT_MAX) begin
                        word_cnt_nxt_s = word_cnt_r + LEN_W'(1);
                    end else begin
                        word_cnt_nxt_s = word_cnt_r;
                    end
                    if (remaining_r == LEN_W'(1)) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_STREAM;
                    end
                end else begin
                    // Nothing left to send (unreachable): finish without a word.
                    fifo_valid_nxt_s = 1'b0;
                    state_nxt_s      = ST_DONE;
                    done_nxt_s       = 1'b1;
                end
            end

            ST_DONE: begin
                // Retire the LAST word; everything else holds until reset.
                fifo_valid_nxt_s = 1'b0;
                state_nxt_s      = ST_DONE;
            end

            default: begin
                fifo_valid_nxt_s = 1'b0;
                state_nxt_s      = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            remaining_r  <= {LEN_W{1'b0}};
            skip_r       <= {SKIP_W{1'b0}};
            fifo_valid_r <= 1'b0;
            fifo_data_r  <= {(DATA_W+1){1'b0}};
            word_cnt_r   <= {LEN_W{1'b0}};
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            remaining_r  <= remaining_nxt_s;
            skip_r       <= skip_nxt_s;
            fifo_valid_r <= fifo_valid_nxt_s;
            fifo_data_r  <= fifo_data_nxt_s;
            word_cnt_r   <= word_cnt_nxt_s;
            done_r       <= done_nxt_s;
            overflow_r   <= overflow_nxt_s;
        end
    end

    assign fifo.fifo_valid = fifo_valid_r;
    assign fifo.fifo_data  = fifo_data_r;
    assign word_cnt_o      = word_cnt_r;
    assign done_o          = done_r;
    assign overflow_o      = overflow_r;

endmodule
